imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of `cpu`: it receives a byte stream (length header plus little-endian instruction words), writes the words into the instruction memory write port, and holds the core in reset until the image is complete. It replaces `$readmemh` preloading with a synthesizable path that a bench or UART front end can drive. `cpu_rst` connects to the core's active-high `rst`. `mem_*` connects to `instr_mem`'s write port.

## Interface
- `ADDR_W`, default 8: word-address width. Instruction memory depth is 2^ADDR_W words.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: **asynchronous, active-low** reset.
- `start` in 1: single-cycle request to begin a load. Honoured only in IDLE or DONE.
- `in_valid` in 1: upstream byte valid.
- `in_data` in 8: upstream byte.
- `in_ready` out 1: loader can accept a byte. A byte transfers on a rising edge where `in_valid && in_ready`.
- `mem_we` out 1: one-cycle write strobe to instruction memory.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: word for the write.
- `cpu_rst` out 1: active-high reset to the core. High means the core is held.
- `busy` out 1: load in progress (LEN_LO, LEN_HI or DATA).
- `done` out 1: last load completed.
- `err` out 1: header word count exceeded 2^ADDR_W.

## Operation
- **States:** IDLE, LEN_LO, LEN_HI, DATA, DONE.
- **Reset values:** state IDLE; `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst`=1, `busy`=0, `done`=0, `err`=0. Internal word count, byte index and word index are all cleared.
- **IDLE / DONE:**
  - `start` moves to LEN_LO.
  - On that move, clear `done`, `err`, word index and byte index, and set `cpu_rst`=1.
  - Without `start`, the state holds.
- **LEN_LO:** accept one byte into count[7:0], then go to LEN_HI.
- **LEN_HI:** accept one byte into count[15:8].
  - If the full count N=0, go to DONE.
  - Otherwise go to DATA.
  - If N > 2^ADDR_W, set `err`=1.
- **DATA:**
  - Byte k (k=0..3) of each word lands in bits [8k+7:8k] (little-endian).
  - On acceptance of byte 3, register a write: `mem_we`=1, `mem_addr`=word index, `mem_wdata`=assembled word.
  - Then increment the word index and decrement the remaining count.
  - Words with index ≥ 2^ADDR_W are consumed but not written (`mem_we` stays 0). `mem_addr` never wraps onto earlier words.
  - When the final word's byte 3 is accepted, go to DONE.
- **DONE:** `done`=1, `cpu_rst`=0, `busy`=0, `in_ready`=0. Stays here until `start` or `rst`.
- **Handshake:**
  - `in_ready` = 1 exactly in LEN_LO, LEN_HI and DATA.
  - Bytes offered while `in_ready`=0 are not consumed.
  - `in_valid` gaps of any length are legal. The partial word is held across gaps.
- **Ignored start:** `start` while `busy` is ignored.
- **Reset mid-load:** all registers return to reset values and the partial word is discarded. Memory words already written are not erased. `cpu_rst` stays high.

## Timing
- All outputs are registered. `in_ready` and `busy` are decoded from the state register.
- **Start latency:** `start` sampled at edge t gives `busy`=1 and `in_ready`=1 from t.
- **Write latency:** byte 3 accepted at edge t gives `mem_we`=1 for exactly the cycle t..t+1 with the matching `mem_addr`/`mem_wdata`. `mem_we` is 0 in every other cycle.
- **Completion, N>0:** final byte accepted at edge t gives the final `mem_we` in cycle t..t+1. `done`=1 and `cpu_rst`=0 from edge t+1, so the core never fetches before the last word is written.
- **Completion, N=0:** high length byte accepted at edge t gives `done`=1 and `cpu_rst`=0 from edge t+1. No `mem_we`.
- **Restart from DONE:** `cpu_rst` rises at the edge sampling `start`.
- **Throughput:** one byte per cycle sustained. A full word takes 4 cycles minimum.

## Test plan
- **Reset values:** assert `rst`=0 asynchronously mid-cycle. Every output takes its reset value immediately (`cpu_rst`=1, others 0) with no clock edge needed.
- **Basic load:** `start`, then bytes 02 00 93 00 50 00 13 01 A0 00 with `in_valid` held high.
  - Expect word 0 = 0x00500093 and word 1 = 0x00A00113, two `mem_we` pulses only.
  - `done`=1 and `cpu_rst`=0 one cycle after the second write; the core then runs `addi x1,x0,5` and `x1`=5.
- **Back-pressure:** same stream with random `in_valid` gaps (0–5 cycles). Identical memory contents, exactly two writes, no duplicated or dropped bytes.
- **Empty image:** header 00 00. `done` rises on the edge after the high byte, with no `mem_we`. A later `start` re-asserts `cpu_rst` on the next edge.
- **Overflow:** `ADDR_W`=2, header 05 00, then 20 bytes.
  - Expect 4 writes to addresses 0..3 and `err`=1 from the header.
  - The 5th word is consumed without a write; `done`=1 at the end.
- **Reset mid-load:** pull `rst` low after 6 bytes (one word written). Loader returns to IDLE with `cpu_rst`=1. A full reload after `start` then completes correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: length header then little-endian words into instruction memory, core held in reset until done.
// Write strobe is one cycle after byte 3 is accepted; done/cpu_rst release follows one edge later; in_ready only while loading.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE} state_t;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [23:0]       part_q, part_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       hdr_n;
  logic              accept;

  assign busy      = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign in_ready  = busy;
  assign accept    = in_valid && in_ready;
  assign hdr_n     = {in_data, count_q[7:0]};
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    part_d      = part_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LEN_LO;
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
          cpu_rst_d  = 1'b1;
        end else if (state_q == DONE) begin
          // Released one edge after entering DONE so the last write lands first
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          count_d[15:8] = in_data;
          if ({1'b0, hdr_n} > DEPTH) err_d = 1'b1;
          state_d = (hdr_n == 16'd0) ? DONE : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0:    part_d[7:0]   = in_data;
            2'd1:    part_d[15:8]  = in_data;
            2'd2:    part_d[23:16] = in_data;
            default: begin
              // Words past the memory end are swallowed; the index saturates at DEPTH
              if (!word_idx_q[ADDR_W]) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = word_idx_q[ADDR_W-1:0];
                mem_wdata_d = {in_data, part_q};
                word_idx_d  = word_idx_q + 1'b1;
              end
              count_d = count_q - 16'd1;
              if (count_q == 16'd1) state_d = DONE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      part_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      part_q      <= part_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default-depth instance plus a 4-word instance for overflow.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start1, in_valid1, in_ready1, mem_we1, cpu_rst1, busy1, done1, err1;
  logic [7:0]  in_data1, mem_addr1;
  logic [31:0] mem_wdata1;
  logic        start2, in_valid2, in_ready2, mem_we2, cpu_rst2, busy2, done2, err2;
  logic [7:0]  in_data2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;

  int checks = 0;
  int errors = 0;
  int wr1 = 0;
  int wr2 = 0;
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [4];

  logic [7:0] basic_stream [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
  int gaps [10] = '{3, 0, 5, 1, 0, 2, 4, 0, 1, 5};

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_rst(cpu_rst1), .busy(busy1), .done(done1), .err(err1));

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .cpu_rst(cpu_rst2), .busy(busy2), .done(done2), .err(err2));

  // Memory models capture each write strobe once, mid-cycle
  always @(negedge clk) begin
    if (mem_we1) begin mem1[mem_addr1] = mem_wdata1; wr1++; end
    if (mem_we2) begin mem2[mem_addr2] = mem_wdata2; wr2++; end
  end

  task automatic clear_models();
    for (int i = 0; i < 256; i++) mem1[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem2[i] = 32'h0;
    wr1 = 0;
    wr2 = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input bit which);
    if (which) start2 = 1'b1; else start1 = 1'b1;
    step();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send_byte(input bit which, input logic [7:0] b);
    int t;
    t = 0;
    if (which) begin in_valid2 = 1'b1; in_data2 = b; end
    else begin in_valid1 = 1'b1; in_data1 = b; end
    while (!(which ? in_ready2 : in_ready1) && t < 50) begin step(); t++; end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL send_byte_timeout: in_ready=0 after %0d cycles, required 1", t);
    end else step();
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h0;
    start2 = 1'b0; in_valid2 = 1'b0; in_data2 = 8'h0;
    clear_models();
    repeat (2) step();
    rst = 1'b1;
    step();
    do_start(1'b0);
    send_byte(1'b0, 8'h02);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b want 1", busy1); end
    #3 rst = 1'b0;
    #1;
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (cpu_rst1 !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst1); end
    checks++; if (mem_we1 !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we1); end
    checks++; if (mem_addr1 !== 8'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr1); end
    checks++; if (mem_wdata1 !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata1); end
    checks++; if ({done1, err1} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b want 00", {done1, err1}); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_load();
    clear_models();
    do_start(1'b0);
    checks++; if ({busy1, in_ready1, cpu_rst1, done1} !== 4'b1110) begin errors++; $display("FAIL basic_start: busy,rdy,rst,done=%b want 1110", {busy1, in_ready1, cpu_rst1, done1}); end
    for (int i = 0; i < 10; i++) begin
      send_byte(1'b0, basic_stream[i]);
      if (i == 5) begin
        checks++; if ({mem_we1, mem_addr1, mem_wdata1} !== {1'b1, 8'h00, 32'h00500093}) begin errors++; $display("FAIL basic_write0: we=%b addr=%h data=%h want 1 00 00500093", mem_we1, mem_addr1, mem_wdata1); end
      end
    end
    checks++; if ({mem_we1, mem_addr1, mem_wdata1} !== {1'b1, 8'h01, 32'h00A00113}) begin errors++; $display("FAIL basic_write1: we=%b addr=%h data=%h want 1 01 00A00113", mem_we1, mem_addr1, mem_wdata1); end
    checks++; if ({done1, cpu_rst1, in_ready1} !== 3'b010) begin errors++; $display("FAIL basic_not_yet_done: done,rst,rdy=%b want 010", {done1, cpu_rst1, in_ready1}); end
    step();
    checks++; if ({done1, cpu_rst1, busy1, mem_we1} !== 4'b1000) begin errors++; $display("FAIL basic_done: done,rst,busy,we=%b want 1000", {done1, cpu_rst1, busy1, mem_we1}); end
    step();
    checks++; if (mem1[0] !== 32'h00500093) begin errors++; $display("FAIL basic_mem0: got %h want 00500093", mem1[0]); end
    checks++; if (mem1[1] !== 32'h00A00113) begin errors++; $display("FAIL basic_mem1: got %h want 00A00113", mem1[1]); end
    checks++; if (wr1 !== 2) begin errors++; $display("FAIL basic_write_count: got %0d want 2", wr1); end
  endtask

  task automatic test_back_pressure();
    clear_models();
    do_start(1'b0);
    checks++; if ({cpu_rst1, done1} !== 2'b10) begin errors++; $display("FAIL bp_restart: rst,done=%b want 10", {cpu_rst1, done1}); end
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        if (i == 3 && g == 0) start1 = 1'b1;
        step();
        start1 = 1'b0;
      end
      if (i == 3) begin
        checks++; if ({busy1, cpu_rst1} !== 2'b11) begin errors++; $display("FAIL bp_start_ignored: busy,rst=%b want 11", {busy1, cpu_rst1}); end
      end
      send_byte(1'b0, basic_stream[i]);
    end
    repeat (2) step();
    checks++; if (mem1[0] !== 32'h00500093) begin errors++; $display("FAIL bp_mem0: got %h want 00500093", mem1[0]); end
    checks++; if (mem1[1] !== 32'h00A00113) begin errors++; $display("FAIL bp_mem1: got %h want 00A00113", mem1[1]); end
    checks++; if (wr1 !== 2) begin errors++; $display("FAIL bp_write_count: got %0d want 2", wr1); end
    checks++; if ({done1, cpu_rst1} !== 2'b10) begin errors++; $display("FAIL bp_done: done,rst=%b want 10", {done1, cpu_rst1}); end
  endtask

  task automatic test_empty_image();
    clear_models();
    do_start(1'b0);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h00);
    checks++; if ({busy1, in_ready1, done1, cpu_rst1} !== 4'b0001) begin errors++; $display("FAIL empty_after_hdr: busy,rdy,done,rst=%b want 0001", {busy1, in_ready1, done1, cpu_rst1}); end
    step();
    checks++; if ({done1, cpu_rst1} !== 2'b10) begin errors++; $display("FAIL empty_done: done,rst=%b want 10", {done1, cpu_rst1}); end
    in_valid1 = 1'b1; in_data1 = 8'h5A;
    repeat (3) step();
    in_valid1 = 1'b0;
    checks++; if ({in_ready1, done1, busy1} !== 3'b010) begin errors++; $display("FAIL empty_ignore_bytes: rdy,done,busy=%b want 010", {in_ready1, done1, busy1}); end
    checks++; if (wr1 !== 0) begin errors++; $display("FAIL empty_no_write: got %0d writes want 0", wr1); end
    do_start(1'b0);
    checks++; if ({cpu_rst1, done1, busy1} !== 3'b101) begin errors++; $display("FAIL empty_restart: rst,done,busy=%b want 101", {cpu_rst1, done1, busy1}); end
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h00);
    step();
  endtask

  task automatic test_overflow();
    clear_models();
    do_start(1'b1);
    send_byte(1'b1, 8'h05);
    send_byte(1'b1, 8'h00);
    checks++; if ({err2, busy2} !== 2'b11) begin errors++; $display("FAIL ovf_err: err,busy=%b want 11", {err2, busy2}); end
    for (int j = 0; j < 20; j++) send_byte(1'b1, 8'(j + 1));
    checks++; if ({mem_we2, done2} !== 2'b00) begin errors++; $display("FAIL ovf_last_word: we,done=%b want 00", {mem_we2, done2}); end
    step();
    checks++; if ({done2, cpu_rst2, err2} !== 3'b101) begin errors++; $display("FAIL ovf_done: done,rst,err=%b want 101", {done2, cpu_rst2, err2}); end
    checks++; if (wr2 !== 4) begin errors++; $display("FAIL ovf_write_count: got %0d want 4", wr2); end
    checks++; if (mem2[0] !== 32'h04030201) begin errors++; $display("FAIL ovf_mem0: got %h want 04030201", mem2[0]); end
    checks++; if (mem2[3] !== 32'h100F0E0D) begin errors++; $display("FAIL ovf_mem3: got %h want 100F0E0D", mem2[3]); end
    checks++; if (mem_addr2 !== 2'd3) begin errors++; $display("FAIL ovf_addr_nowrap: got %0d want 3", mem_addr2); end
  endtask

  task automatic test_reset_mid_load();
    clear_models();
    do_start(1'b0);
    for (int i = 0; i < 6; i++) send_byte(1'b0, basic_stream[i]);
    checks++; if (mem_we1 !== 1'b1) begin errors++; $display("FAIL mid_write0: got %b want 1", mem_we1); end
    @(negedge clk); #1 rst = 1'b0;
    #1;
    checks++; if ({busy1, in_ready1, cpu_rst1, mem_we1} !== 4'b0010) begin errors++; $display("FAIL mid_reset_ctl: busy,rdy,rst,we=%b want 0010", {busy1, in_ready1, cpu_rst1, mem_we1}); end
    checks++; if (mem_wdata1 !== 32'h0) begin errors++; $display("FAIL mid_reset_wdata: got %h want 0", mem_wdata1); end
    checks++; if (wr1 !== 1) begin errors++; $display("FAIL mid_write_count: got %0d want 1", wr1); end
    step();
    rst = 1'b1;
    step();
    do_start(1'b0);
    for (int i = 0; i < 10; i++) send_byte(1'b0, basic_stream[i]);
    repeat (2) step();
    checks++; if (mem1[1] !== 32'h00A00113) begin errors++; $display("FAIL mid_reload_mem1: got %h want 00A00113", mem1[1]); end
    checks++; if (wr1 !== 3) begin errors++; $display("FAIL mid_reload_count: got %0d want 3", wr1); end
    checks++; if ({done1, cpu_rst1} !== 2'b10) begin errors++; $display("FAIL mid_reload_done: done,rst=%b want 10", {done1, cpu_rst1}); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_back_pressure();
    test_empty_image();
    test_overflow();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
